hazard_ctrl: RTL and testbench

- Pipeline hazard controller: sequences the Fetch-Decode pipeline register (stall_D / flush_F) and the Decode-Execute register.
- Detects load-use hazards, resolves taken-branch flushes and holds the front end for multi-cycle Execute operations.
- Keeps a saturating stall-cycle counter for performance debug.
- Sits beside the pipeline registers; all its outputs go straight to their wen/rst controls.

---
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the F/D and D/E pipeline registers.
//   Detects load-use hazards, flushes on taken branches, and freezes the front end
//   while a multi-cycle Execute operation runs. Keeps a saturating count of
//   cycles in which the F/D register was held.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   rs1_D, rs2_D         Decode source registers; use_rs1_D/use_rs2_D qualify them
//   rd_E, memread_E      Execute destination register and load flag
//   branch_taken_E       branch resolved taken in Execute
//   mc_start_E           multi-cycle op enters Execute; mc_cycles_E is its length
//   stall_F/stall_D/stall_E, flush_F/flush_D   pipeline register controls
//   mc_busy              multi-cycle operation in progress
//   stall_cnt            saturating count of cycles with stall_D=1
module hazard_ctrl #(
   parameter int unsigned RW = 4,
   parameter int unsigned CW = 4,
   parameter int unsigned SW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [RW-1:0] rs1_D,
   input  logic [RW-1:0] rs2_D,
   input  logic          use_rs1_D,
   input  logic          use_rs2_D,
   input  logic [RW-1:0] rd_E,
   input  logic          memread_E,
   input  logic          branch_taken_E,
   input  logic          mc_start_E,
   input  logic [CW-1:0] mc_cycles_E,
   output logic          stall_F,
   output logic          stall_D,
   output logic          flush_F,
   output logic          stall_E,
   output logic          flush_D,
   output logic          mc_busy,
   output logic [SW-1:0] stall_cnt
);

   typedef enum logic [0:0] {StRun, StMcBusy} state_t;

   state_t        r_state;
   state_t        w_state_d;
   logic [CW-1:0] r_mcnt;
   logic [CW-1:0] w_mcnt_d;
   logic [SW-1:0] r_stall_cnt;
   logic          w_lu;
   logic          w_stall_F;
   logic          w_stall_D;
   logic          w_flush_F;
   logic          w_stall_E;
   logic          w_flush_D;
   logic          w_mc_busy;

   // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
   assign w_lu = memread_E && (rd_E != '0) &&
                 ((use_rs1_D && (rs1_D == rd_E)) || (use_rs2_D && (rs2_D == rd_E)));

   always_comb begin
      w_state_d = r_state;
      w_mcnt_d  = r_mcnt;
      w_stall_F = 1'b0;
      w_stall_D = 1'b0;
      w_flush_F = 1'b0;
      w_stall_E = 1'b0;
      w_flush_D = 1'b0;
      w_mc_busy = 1'b0;
      unique case (r_state)
         StRun: begin
            if (branch_taken_E) begin
               // Decode holds a wrong-path instruction, so any load-use match is moot.
               w_flush_F = 1'b1;
               w_flush_D = 1'b1;
            end else if (w_lu) begin
               w_stall_F = 1'b1;
               w_stall_D = 1'b1;
               w_flush_D = 1'b1;
            end
            // The start cycle itself is the first Execute cycle; the rest are stalls.
            if (mc_start_E && (mc_cycles_E > CW'(1))) begin
               w_state_d = StMcBusy;
               w_mcnt_d  = mc_cycles_E - CW'(1);
            end
         end
         StMcBusy: begin
            w_stall_F = 1'b1;
            w_stall_D = 1'b1;
            w_stall_E = 1'b1;
            w_mc_busy = 1'b1;
            if (r_mcnt <= CW'(1)) begin
               w_state_d = StRun;
               w_mcnt_d  = '0;
            end else begin
               w_mcnt_d  = r_mcnt - CW'(1);
            end
         end
         default: begin
            w_state_d = StRun;
            w_mcnt_d  = '0;
         end
      endcase
   end

   // Outputs are forced low during reset even though the inputs may show a hazard.
   assign stall_F   = rst & w_stall_F;
   assign stall_D   = rst & w_stall_D;
   assign flush_F   = rst & w_flush_F;
   assign stall_E   = rst & w_stall_E;
   assign flush_D   = rst & w_flush_D;
   assign mc_busy   = rst & w_mc_busy;
   assign stall_cnt = r_stall_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= StRun;
         r_mcnt      <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state <= w_state_d;
         r_mcnt  <= w_mcnt_d;
         if (w_stall_D && (r_stall_cnt != {SW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + SW'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random stimulus,
// compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

   localparam int unsigned RW = 4;
   localparam int unsigned CW = 4;
   localparam int unsigned SW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [RW-1:0] rs1_D, rs2_D, rd_E;
   logic          use_rs1_D, use_rs2_D, memread_E, branch_taken_E, mc_start_E;
   logic [CW-1:0] mc_cycles_E;
   logic          stall_F, stall_D, flush_F, stall_E, flush_D, mc_busy;
   logic [SW-1:0] stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: remaining multi-cycle stall cycles and the stall counter.
   int m_busy_left = 0;
   int m_cnt = 0;
   localparam int CntMax = (1 << SW) - 1;

   hazard_ctrl #(.RW(RW), .CW(CW), .SW(SW)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .rs1_D          (rs1_D),
      .rs2_D          (rs2_D),
      .use_rs1_D      (use_rs1_D),
      .use_rs2_D      (use_rs2_D),
      .rd_E           (rd_E),
      .memread_E      (memread_E),
      .branch_taken_E (branch_taken_E),
      .mc_start_E     (mc_start_E),
      .mc_cycles_E    (mc_cycles_E),
      .stall_F        (stall_F),
      .stall_D        (stall_D),
      .flush_F        (flush_F),
      .stall_E        (stall_E),
      .flush_D        (flush_D),
      .mc_busy        (mc_busy),
      .stall_cnt      (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_lu();
      if (!memread_E || rd_E == 0) return 1'b0;
      return (use_rs1_D && rs1_D == rd_E) || (use_rs2_D && rs2_D == rd_E);
   endfunction

   // {stall_F, stall_D, flush_F, stall_E, flush_D, mc_busy}
   function automatic logic [5:0] model_out();
      if (!rst) return 6'b000000;
      if (m_busy_left > 0) return 6'b110101;
      if (branch_taken_E) return 6'b001010;
      if (model_lu()) return 6'b110010;
      return 6'b000000;
   endfunction

   task automatic set_idle();
      rs1_D = '0; rs2_D = '0; rd_E = '0;
      use_rs1_D = 0; use_rs2_D = 0; memread_E = 0;
      branch_taken_E = 0; mc_start_E = 0; mc_cycles_E = '0;
   endtask

   // Called just after a negedge with inputs already driven: check, clock, update model.
   task automatic step(input string tag);
      logic [5:0] e;
      if (!rst) begin
         m_busy_left = 0;
         m_cnt = 0;
      end
      #1;
      e = model_out();
      check({tag, ".out"}, {26'b0, stall_F, stall_D, flush_F, stall_E, flush_D, mc_busy},
            {26'b0, e});
      check({tag, ".cnt"}, 32'(stall_cnt), 32'(m_cnt));
      @(posedge clk);
      if (rst) begin
         if (e[4] && m_cnt < CntMax) m_cnt++;
         if (m_busy_left > 0) m_busy_left--;
         else if (mc_start_E && mc_cycles_E >= 2) m_busy_left = int'(mc_cycles_E) - 1;
      end
      @(negedge clk);
   endtask

   task automatic reset_pulse();
      rst = 1'b0;
      set_idle();
      step("rstp");
      rst = 1'b1;
   endtask

   int cnt0;

   initial begin
      set_idle();
      rst = 1'b0;
      @(negedge clk);

      // Reset masks a live load-use hazard.
      memread_E = 1; rd_E = 3; rs1_D = 3; use_rs1_D = 1;
      #1;
      check("rst_outs", {stall_F, stall_D, flush_F, stall_E, flush_D, mc_busy}, 6'b0);
      check("rst_cnt", 32'(stall_cnt), 32'd0);
      step("rst");
      rst = 1'b1;
      #1;
      check("rel_lu", {stall_F, stall_D, flush_D}, 3'b111);
      #1;
      step("rel");

      // Load-use on rs2 for one cycle, then clear.
      reset_pulse();
      set_idle();
      memread_E = 1; rd_E = 5; rs2_D = 5; use_rs2_D = 1;
      step("lu2");
      memread_E = 0;
      step("lu2_after");
      check("lu_cnt1", 32'(stall_cnt), 32'd1);
      // Load into x0 never stalls.
      memread_E = 1; rd_E = 0; rs2_D = 0;
      step("lu_x0");

      // Branch wins over load-use.
      set_idle();
      memread_E = 1; rd_E = 2; rs1_D = 2; use_rs1_D = 1; branch_taken_E = 1;
      step("br_pri");

      // Multi-cycle, 4 cycles: 3 stall cycles after start.
      reset_pulse();
      set_idle();
      mc_start_E = 1; mc_cycles_E = 4;
      step("mc_start");
      set_idle();
      for (int i = 0; i < 4; i++) step("mc4");
      check("mc_cnt3", 32'(stall_cnt), 32'd3);
      mc_start_E = 1; mc_cycles_E = 1;
      step("mc1");
      set_idle();
      step("mc1_after");

      // Busy masking: branch and new start ignored during MC_BUSY.
      mc_start_E = 1; mc_cycles_E = 5;
      step("mask_start");
      branch_taken_E = 1; mc_start_E = 1; mc_cycles_E = 9;
      memread_E = 1; rd_E = 7; rs1_D = 7; use_rs1_D = 1;
      for (int i = 0; i < 4; i++) step("mask_busy");
      set_idle();
      step("mask_exit");

      // Saturation with a held load-use stall.
      reset_pulse();
      memread_E = 1; rd_E = 6; rs1_D = 6; use_rs1_D = 1;
      for (int i = 0; i < 20; i++) step("sat");
      check("sat15", 32'(stall_cnt), 32'd15);

      // Async reset mid-busy, no clock edge involved.
      set_idle();
      mc_start_E = 1; mc_cycles_E = 6;
      step("ar_start");
      set_idle();
      step("ar_busy");
      #2;
      rst = 1'b0;
      #1;
      check("ar_outs", {stall_F, stall_D, flush_F, stall_E, flush_D, mc_busy}, 6'b0);
      check("ar_cnt", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      step("ar_hold");
      rst = 1'b1;
      step("ar_rel");

      // Random stimulus.
      for (int i = 0; i < 600; i++) begin
         rs1_D = RW'($urandom_range(0, 3));
         rs2_D = RW'($urandom_range(0, 3));
         rd_E = RW'($urandom_range(0, 3));
         use_rs1_D = 1'($urandom);
         use_rs2_D = 1'($urandom);
         memread_E = ($urandom_range(0, 2) != 0);
         branch_taken_E = ($urandom_range(0, 5) == 0);
         mc_start_E = ($urandom_range(0, 7) == 0);
         mc_cycles_E = CW'($urandom);
         rst = ($urandom_range(0, 99) != 0);
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
